// File: rtl/proc_fix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_fix_pkg : opcodes and divider state encoding for proc_fix       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package proc_fix_pkg;

    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ula_div_seq_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step : one restoring radix-2 iteration (shift, trial subtract)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_step #(
    parameter int NUBITS = 32
) (
    input  logic [NUBITS-1:0] rem,
    input  logic [NUBITS-1:0] quo,
    input  logic [NUBITS-1:0] divisor,
    output logic [NUBITS-1:0] rem_next,
    output logic [NUBITS-1:0] quo_next
);

    logic [NUBITS:0] shifted;
    logic [NUBITS:0] diff;

    // remainder < divisor always holds, so a non-negative difference fits NUBITS bits
    always_comb begin
        shifted = {rem, quo[NUBITS-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[NUBITS]) begin
            rem_next = diff[NUBITS-1:0];
            quo_next = {quo[NUBITS-2:0], 1'b1};
        end else begin
            rem_next = shifted[NUBITS-1:0];
            quo_next = {quo[NUBITS-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ula_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_div_seq : multi-cycle signed DIV/MOD responder for proc_fix      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ula_div_seq
    import proc_fix_pkg::*;
#(
    parameter int         NUBITS = 32,
    parameter logic [4:0] OPDIV  = OP_DIV,
    parameter logic [4:0] OPMOD  = OP_MOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [NUBITS-1:0] in1,
    input  logic [NUBITS-1:0] in2,
    output logic              busy,
    output logic              done,
    output logic [NUBITS-1:0] out,
    output logic              dz
);

    localparam int CW = $clog2(NUBITS) + 1;

    div_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUBITS-1:0] rem_q, rem_d;
    logic [NUBITS-1:0] quo_q, quo_d;
    logic [NUBITS-1:0] div_q, div_d;
    logic              sel_q, sel_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dzp_q, dzp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUBITS-1:0] out_q, out_d;
    logic              dz_q, dz_d;

    logic [NUBITS-1:0] step_rem, step_quo;
    logic [NUBITS-1:0] abs_a, abs_b, rem_fix, quo_fix;
    logic              accept;

    div_step #(.NUBITS(NUBITS)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        sel_d   = sel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzp_d   = dzp_q;
        out_d   = out_q;
        dz_d    = dz_q;

        abs_a   = in1[NUBITS-1] ? -in1 : in1;
        abs_b   = in2[NUBITS-1] ? -in2 : in2;
        rem_fix = rneg_q ? -rem_q : rem_q;
        quo_fix = qneg_q ? -quo_q : quo_q;
        accept  = start && ((op == OPDIV) || (op == OPMOD));

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    sel_d  = (op == OPMOD);
                    qneg_d = in1[NUBITS-1] ^ in2[NUBITS-1];
                    rneg_d = in1[NUBITS-1];
                    div_d  = abs_b;
                    cnt_d  = CW'(NUBITS);
                    dzp_d  = (in2 == '0);
                    // zero divisor: park |in1| in rem so the sign fix-up restores in1 for MOD
                    if (in2 == '0) begin
                        rem_d   = abs_a;
                        quo_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                out_d   = sel_q ? rem_fix : (dzp_q ? '1 : quo_fix);
                dz_d    = dzp_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            sel_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzp_q   <= dzp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign dz   = dz_q;

endmodule
`default_nettype wire

// File: doc/ula_div_seq.md
Name: ula_div_seq

Overview:
- Multi-cycle signed divide/modulo responder for the proc_fix datapath.
- Serves opcodes DIV (5'd4) and MOD (5'd5) when the combinational ALU is built with DIV=0/MOD=0, so no single-cycle array divider is synthesized.
- The control unit issues a request and stalls on busy. The block returns the result on the same NUBITS-wide result path the ALU drives.
- Restoring radix-2 divider, one quotient bit per clock.

Parameters:
- NUBITS, 32, operand/result width in bits (>=4).
- OPDIV, 5'd4, opcode selecting quotient.
- OPMOD, 5'd5, opcode selecting remainder.

Ports:
- clk    input   1       system clock, rising edge.
- rst    input   1       asynchronous, active-low reset.
- start  input   1       request strobe, sampled on clk rising edge.
- op     input   5       opcode; accepted only when equal to OPDIV or OPMOD.
- in1    input   NUBITS  signed dividend.
- in2    input   NUBITS  signed divisor.
- busy   output  1       high while a division is in progress.
- done   output  1       one-cycle pulse when out is valid.
- out    output  NUBITS  signed quotient or remainder; holds value until next accepted start.
- dz     output  1       divide-by-zero flag for the last result; held with out.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, out=0, dz=0; counter, working registers and sel cleared.
- States:
  - IDLE: busy=0.
  - CALC: busy=1.
  - FIX: busy=1.
  - DONE: busy=0, done=1.
- IDLE, or DONE, with start=1 and op in {OPDIV,OPMOD}:
  - Register sel=(op==OPMOD), sign of quotient = in1[MSB]^in2[MSB], sign of remainder = in1[MSB].
  - Register |in1| and |in2| as NUBITS-bit unsigned values; |MIN| = 2^(NUBITS-1) fits unsigned.
  - Clear partial remainder, load counter=NUBITS, go to CALC.
- start with any other op: ignored, no state change, no done.
- start while busy=1: ignored. in1, in2 and op are not re-sampled mid-operation.
- CALC, each cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract divisor from the NUBITS+1-bit remainder. If non-negative, keep the difference and set the quotient LSB to 1.
  - Decrement counter; leave for FIX when counter reaches 1 (exactly NUBITS CALC cycles).
- FIX (1 cycle):
  - Apply signs: quotient negated if its sign bit is set; remainder negated if dividend negative.
  - Truncation toward zero; remainder takes the sign of the dividend.
  - Write out = sel ? rem : quo. Go to DONE.
- DONE (1 cycle): done=1, then IDLE. A start in DONE is accepted (back-to-back issue).
- Latency: done is high in the clock cycle following the (NUBITS+2)th rising edge after the accepting edge. NUBITS=32 gives 34 edges.
- Divide by zero (in2==0), detected at accept:
  - Skip CALC and go to FIX next cycle; latency is 2 edges.
  - out = sel ? in1 : all-ones (-1); dz=1.
- Overflow (in1 = -2^(NUBITS-1), in2 = -1): quotient = -2^(NUBITS-1) (wrap), remainder = 0, dz=0. This falls out of the unsigned datapath; no special case is needed.
- dz cleared on every accepted non-zero-divisor request (written in FIX).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; partial result discarded; no done.
- out is unchanged between done and the next accepted start's FIX cycle.

Decomposition:
- Shared package proc_fix_pkg holds:
  - opcode constants OP_DIV=5'd4, OP_MOD=5'd5 (shared with ula_fx and the control unit);
  - state encoding localparams S_IDLE, S_CALC, S_FIX, S_DONE.
- One natural sub-module, div_step: combinational single iteration. Inputs: rem, quo, divisor. Outputs: next rem/quo.
- The top holds the FSM, counter ($clog2(NUBITS)+1 bits), sign registers and output register.

Test Plan (NUBITS=32):
- 100 / 7 with OPDIV -> done after 34 edges, out=14, dz=0; repeat with OPMOD -> out=2.
- -100 / 7 -> OPDIV out=-14, OPMOD out=-2; 100 / -7 -> OPDIV -14, OPMOD 2; -100 / -7 -> OPDIV 14, OPMOD -2.
- 7 / 0 with OPDIV -> done after 2 edges, out=32'hFFFFFFFF, dz=1; OPMOD -> out=7, dz=1; next 9/3 clears dz, out=3.
- 32'h80000000 / -1 with OPDIV -> out=32'h80000000, dz=0; OPMOD -> out=0.
- start pulsed at cycle 10 of a busy 1000/10 with in1=5,in2=5: ignored, out=100. Then start in the DONE cycle with 50 %7 is accepted -> out=1.
- rst low at CALC cycle 15 -> busy=0, done=0, out=0 asynchronously; no done pulse afterwards. op=5'd2 with start -> no response.
